// File: rtl/cdb_arbiter.sv
// Complete-stage CDB arbiter: one-entry result buffer per functional unit,
// round-robin grant of one buffered result per cycle onto the common data bus.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int ROB_W   = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*ROB_W-1:0]  req_rob_idx,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_en,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [ROB_W-1:0]          cdb_rob_idx,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [NUM_REQ-1:0]        cdb_grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] buf_valid;
  logic [TAG_W-1:0]   buf_tag     [NUM_REQ];
  logic [ROB_W-1:0]   buf_rob_idx [NUM_REQ];
  logic [DATA_W-1:0]  buf_data    [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr;

  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;

  // Two-pass priority search: first entries at or above rr_ptr, then the
  // wrapped-around low entries. Only registered state and flush are used.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && buf_valid[i] && (i >= int'(rr_ptr))) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && buf_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
    if (flush) begin
      grant_any = 1'b0;
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = grant_any && (grant_idx == PTR_W'(i));
    end
  end

  always_comb begin
    cdb_tag     = '0;
    cdb_rob_idx = '0;
    cdb_data    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        cdb_tag     = buf_tag[i];
        cdb_rob_idx = buf_rob_idx[i];
        cdb_data    = buf_data[i];
      end
    end
  end

  assign cdb_en    = grant_any;
  assign cdb_grant = grant;

  // A granted entry frees its slot this cycle, so the unit may refill it
  // at the same edge the old result leaves.
  assign req_ready = {NUM_REQ{reset & ~flush}} & (~buf_valid | grant);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_tag[i]     <= '0;
        buf_rob_idx[i] <= '0;
        buf_data[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flush) begin
          buf_valid[i] <= 1'b0;
        end else if (req_valid[i] && req_ready[i]) begin
          buf_valid[i]   <= 1'b1;
          buf_tag[i]     <= req_tag[i*TAG_W +: TAG_W];
          buf_rob_idx[i] <= req_rob_idx[i*ROB_W +: ROB_W];
          buf_data[i]    <= req_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= grant_idx + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, round-robin contention,
// back-to-back replace-on-grant, flush and asynchronous reset mid-operation.
module tb_cdb_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 6;
  localparam int ROB_W   = 5;
  localparam int DATA_W  = 32;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*ROB_W-1:0]  req_rob_idx;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cdb_en;
  logic [TAG_W-1:0]          cdb_tag;
  logic [ROB_W-1:0]          cdb_rob_idx;
  logic [DATA_W-1:0]         cdb_data;
  logic [NUM_REQ-1:0]        cdb_grant;

  int checks = 0;
  int passed = 0;

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_rob_idx(req_rob_idx), .req_data(req_data),
    .req_ready(req_ready), .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_rob_idx(cdb_rob_idx),
    .cdb_data(cdb_data), .cdb_grant(cdb_grant)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid   = '0;
    req_tag     = '0;
    req_rob_idx = '0;
    req_data    = '0;
  endtask

  task automatic set_req(input int i, input int t, input int r, input int d);
    req_valid[i]                  = 1'b1;
    req_tag[i*TAG_W +: TAG_W]     = TAG_W'(t);
    req_rob_idx[i*ROB_W +: ROB_W] = ROB_W'(r);
    req_data[i*DATA_W +: DATA_W]  = DATA_W'(d);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    flush = 1'b0;
    clear_reqs();
    repeat (2) step();
    checks++; if (req_ready !== 4'b0000) $display("FAIL rst_ready got=%b exp=0000", req_ready); else passed++;
    checks++; if (cdb_en !== 1'b0) $display("FAIL rst_en got=%b exp=0", cdb_en); else passed++;
    checks++; if (cdb_grant !== 4'b0000) $display("FAIL rst_grant got=%b exp=0000", cdb_grant); else passed++;
    checks++; if ({cdb_tag, cdb_rob_idx, cdb_data} !== '0)
      $display("FAIL rst_payload got=%h/%h/%h exp=0", cdb_tag, cdb_rob_idx, cdb_data); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1111) $display("FAIL idle_ready got=%b exp=1111", req_ready); else passed++;
    checks++; if (cdb_en !== 1'b0) $display("FAIL idle_en got=%b exp=0", cdb_en); else passed++;
    checks++; if (cdb_grant !== 4'b0000) $display("FAIL idle_grant got=%b exp=0000", cdb_grant); else passed++;
    checks++; if ({cdb_tag, cdb_rob_idx, cdb_data} !== '0)
      $display("FAIL idle_payload got=%h/%h/%h exp=0", cdb_tag, cdb_rob_idx, cdb_data); else passed++;
  endtask

  task automatic test_single();
    set_req(1, 5, 3, 15);
    #1;
    checks++; if (req_ready[1] !== 1'b1) $display("FAIL single_ready got=%b exp=1", req_ready[1]); else passed++;
    step();
    clear_reqs();
    #1;
    checks++; if (cdb_en !== 1'b1) $display("FAIL single_en got=%b exp=1", cdb_en); else passed++;
    checks++; if (cdb_tag !== 6'd5) $display("FAIL single_tag got=%0d exp=5", cdb_tag); else passed++;
    checks++; if (cdb_rob_idx !== 5'd3) $display("FAIL single_rob got=%0d exp=3", cdb_rob_idx); else passed++;
    checks++; if (cdb_data !== 32'd15) $display("FAIL single_data got=%0d exp=15", cdb_data); else passed++;
    checks++; if (cdb_grant !== 4'b0010) $display("FAIL single_grant got=%b exp=0010", cdb_grant); else passed++;
    step();
    checks++; if (cdb_en !== 1'b0) $display("FAIL single_done_en got=%b exp=0", cdb_en); else passed++;
    checks++; if (cdb_grant !== 4'b0000) $display("FAIL single_done_grant got=%b exp=0000", cdb_grant); else passed++;
    // pointer now at 2: unit 2 must beat unit 0
    set_req(0, 1, 1, 100);
    set_req(2, 2, 2, 200);
    step();
    clear_reqs();
    #1;
    checks++; if (cdb_grant !== 4'b0100) $display("FAIL ptr_first_grant got=%b exp=0100", cdb_grant); else passed++;
    checks++; if (cdb_tag !== 6'd2) $display("FAIL ptr_first_tag got=%0d exp=2", cdb_tag); else passed++;
    step();
    checks++; if (cdb_grant !== 4'b0001) $display("FAIL ptr_second_grant got=%b exp=0001", cdb_grant); else passed++;
    checks++; if (cdb_data !== 32'd100) $display("FAIL ptr_second_data got=%0d exp=100", cdb_data); else passed++;
    step();
    checks++; if (cdb_en !== 1'b0) $display("FAIL ptr_idle_en got=%b exp=0", cdb_en); else passed++;
  endtask

  task automatic test_contention();
    int n [NUM_REQ];
    logic [NUM_REQ-1:0] rdy;
    logic [NUM_REQ-1:0] exp_grant;
    logic [NUM_REQ-1:0] exp_ready;
    int exp_tag;
    logic exp_en;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < NUM_REQ; i++) n[i] = 0;
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        set_req(i, 10 + i + 4 * n[i], 10 + i + 4 * n[i], 256 + 10 + i + 4 * n[i]);
      end
      #1;
      if (c == 0) begin
        exp_en = 1'b0; exp_grant = 4'b0000; exp_ready = 4'b1111; exp_tag = 0;
      end else begin
        exp_en = 1'b1; exp_grant = 4'b0001 << ((c - 1) % 4); exp_ready = exp_grant; exp_tag = 10 + c - 1;
      end
      checks++; if (cdb_en !== exp_en) $display("FAIL rr_en c=%0d got=%b exp=%b", c, cdb_en, exp_en); else passed++;
      checks++; if (cdb_grant !== exp_grant) $display("FAIL rr_grant c=%0d got=%b exp=%b", c, cdb_grant, exp_grant); else passed++;
      checks++; if (req_ready !== exp_ready) $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); else passed++;
      if (c != 0) begin
        checks++; if (cdb_tag !== TAG_W'(exp_tag)) $display("FAIL rr_tag c=%0d got=%0d exp=%0d", c, cdb_tag, exp_tag); else passed++;
        checks++; if (cdb_data !== DATA_W'(256 + exp_tag)) $display("FAIL rr_data c=%0d got=%0d exp=%0d", c, cdb_data, 256 + exp_tag); else passed++;
      end
      rdy = req_ready;
      step();
      for (int i = 0; i < NUM_REQ; i++) if (rdy[i]) n[i]++;
    end
    clear_reqs();
    repeat (5) step();
    checks++; if (cdb_en !== 1'b0) $display("FAIL rr_drain_en got=%b exp=0", cdb_en); else passed++;
  endtask

  task automatic test_back_to_back();
    set_req(2, 20, 20, 2000);
    #1;
    checks++; if (req_ready[2] !== 1'b1) $display("FAIL b2b_ready0 got=%b exp=1", req_ready[2]); else passed++;
    step();
    set_req(2, 21, 21, 2001);
    #1;
    checks++; if (cdb_grant !== 4'b0100) $display("FAIL b2b_grant got=%b exp=0100", cdb_grant); else passed++;
    checks++; if (cdb_tag !== 6'd20) $display("FAIL b2b_tag0 got=%0d exp=20", cdb_tag); else passed++;
    checks++; if (req_ready[2] !== 1'b1) $display("FAIL b2b_ready1 got=%b exp=1", req_ready[2]); else passed++;
    step();
    set_req(2, 22, 22, 2002);
    #1;
    checks++; if (cdb_tag !== 6'd21) $display("FAIL b2b_tag1 got=%0d exp=21", cdb_tag); else passed++;
    checks++; if (req_ready[2] !== 1'b1) $display("FAIL b2b_ready2 got=%b exp=1", req_ready[2]); else passed++;
    step();
    clear_reqs();
    #1;
    checks++; if (cdb_tag !== 6'd22) $display("FAIL b2b_tag2 got=%0d exp=22", cdb_tag); else passed++;
    checks++; if (cdb_data !== 32'd2002) $display("FAIL b2b_data2 got=%0d exp=2002", cdb_data); else passed++;
    step();
    checks++; if (cdb_en !== 1'b0) $display("FAIL b2b_idle_en got=%b exp=0", cdb_en); else passed++;
  endtask

  task automatic test_flush();
    set_req(0, 30, 30, 300);
    set_req(3, 33, 33, 333);
    step();
    clear_reqs();
    flush = 1'b1;
    #1;
    checks++; if (cdb_en !== 1'b0) $display("FAIL flush_en got=%b exp=0", cdb_en); else passed++;
    checks++; if (req_ready !== 4'b0000) $display("FAIL flush_ready got=%b exp=0000", req_ready); else passed++;
    checks++; if (cdb_grant !== 4'b0000) $display("FAIL flush_grant got=%b exp=0000", cdb_grant); else passed++;
    step();
    flush = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b1111) $display("FAIL post_flush_ready got=%b exp=1111", req_ready); else passed++;
    checks++; if (cdb_en !== 1'b0) $display("FAIL post_flush_en got=%b exp=0", cdb_en); else passed++;
    // pointer must still be 3 after the flush
    set_req(0, 40, 40, 400);
    set_req(3, 43, 43, 430);
    step();
    clear_reqs();
    #1;
    checks++; if (cdb_grant !== 4'b1000) $display("FAIL flush_ptr_grant got=%b exp=1000", cdb_grant); else passed++;
    checks++; if (cdb_tag !== 6'd43) $display("FAIL flush_ptr_tag got=%0d exp=43", cdb_tag); else passed++;
    step();
    checks++; if (cdb_grant !== 4'b0001) $display("FAIL flush_wrap_grant got=%b exp=0001", cdb_grant); else passed++;
    checks++; if (cdb_tag !== 6'd40) $display("FAIL flush_wrap_tag got=%0d exp=40", cdb_tag); else passed++;
    step();
    checks++; if (cdb_en !== 1'b0) $display("FAIL flush_idle_en got=%b exp=0", cdb_en); else passed++;
  endtask

  task automatic test_async_reset();
    set_req(0, 50, 50, 500);
    set_req(1, 51, 51, 510);
    set_req(2, 52, 52, 520);
    step();
    clear_reqs();
    #1;
    checks++; if (cdb_tag !== 6'd51) $display("FAIL arst_pre_tag got=%0d exp=51", cdb_tag); else passed++;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (cdb_en !== 1'b0) $display("FAIL arst_en got=%b exp=0", cdb_en); else passed++;
    checks++; if (req_ready !== 4'b0000) $display("FAIL arst_ready got=%b exp=0000", req_ready); else passed++;
    checks++; if (cdb_grant !== 4'b0000) $display("FAIL arst_grant got=%b exp=0000", cdb_grant); else passed++;
    step();
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1111) $display("FAIL arst_rel_ready got=%b exp=1111", req_ready); else passed++;
    for (int c = 0; c < 3; c++) begin
      checks++; if (cdb_en !== 1'b0) $display("FAIL arst_stale_en c=%0d got=%b tag=%0d exp=0", c, cdb_en, cdb_tag); else passed++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
